// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared request/response types, FSM states and byte-enable helpers
package dmem_responder_pkg;
  localparam int BUS_ADDR_W = 30;
  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [3:0]            be;
    logic [31:0]           wdata;
  } mem_req_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_op_sz_t;
  localparam logic [6:0][3:0] LEGAL_BE = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  function automatic logic [3:0] be_from_sz(mem_op_sz_t sz, logic [1:0] off);
    return sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic be_legal(logic [3:0] be);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 7; i++) ok |= be == LEGAL_BE[i];
    return ok;
  endfunction
endpackage

// File: rtl/dmem_responder_sram.sv
// dmem_sram: single-port SRAM with registered read and per-byte write enables
module dmem_sram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with wait states; DMEM_BE_CHECK_EN enables byte-enable legality checking
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 30,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  output logic              req_nack,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  resp_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  mem_req_t in_req, lat, acc_req;
  mem_rsp_t rsp;
  logic accept, access, acc_err, r_we, r_err;
  logic [31:0] q;
  function automatic logic req_err(mem_req_t r);
    logic e;
    e = |(r.addr >> DEPTH_LOG2);
`ifdef DMEM_BE_CHECK_EN
    e |= r.we && !be_legal(r.be);
`endif
    return e;
  endfunction
  always_comb begin
    in_req.we    = req_we;
    in_req.addr  = BUS_ADDR_W'(req_addr);
    in_req.be    = req_be;
    in_req.wdata = req_wdata;
    accept    = req_valid && state != WAIT;
    access    = (accept && WC == 4'd0) || (state == WAIT && cnt == 4'd1);
    acc_req   = state == WAIT ? lat : in_req;
    acc_err   = req_err(acc_req);
    state_n   = state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : accept ? (WC == 4'd0 ? RESP : WAIT) : IDLE;
    cnt_n     = state == WAIT ? cnt - 4'd1 : accept ? WC : cnt;
    rsp.valid = state == RESP;
    rsp.rdata = state == RESP && !r_we && !r_err ? q : 32'd0;
    rsp.err   = state == RESP && r_err;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 4'd0;
      lat   <= '0;
      r_we  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      cnt <= cnt_n;
      if (accept) lat <= in_req;
      if (access) begin
        r_we  <= acc_req.we;
        r_err <= acc_err;
      end
    end
  end
  dmem_sram #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
    .clk  (clk),
    .en   (access && !acc_err && !rst),
    .we   (acc_req.we),
    .addr (acc_req.addr[DEPTH_LOG2-1:0]),
    .be   (acc_req.be),
    .wdata(acc_req.wdata),
    .rdata(q)
  );
  assign req_nack  = req_valid && state == WAIT && !rst;
  assign rsp_valid = rsp.valid;
  assign rsp_rdata = rsp.rdata;
  assign rsp_err   = rsp.err;
endmodule
